// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller and the pipeline top:
// stage index constants, the redirect FSM state type and the default
// pipeline geometry.
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    // Default geometry, shared with the pipeline top.
    localparam int DEF_NSTAGE      = 5;
    localparam int DEF_FLUSH_DEPTH = 2;

    // Stage indices for the default 5-stage core. Fetch has no separate
    // pipeline register: its state is the PC register, so IF aliases PC.
    localparam int STG_PC  = 0;
    localparam int STG_IF  = STG_PC;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    // Redirect FSM: RUN = no redirect outstanding, PEND = redirect latched
    // while the stage that raised it is frozen.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the pipeline and the hazard controller.
//   master (pipeline):   drives stall_req, flush_req; receives the controls.
//   slave  (controller): receives requests; drives stall, bubble, flush,
//                        flush_pending, hang, stall_cycles, flush_count.
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE = DEF_NSTAGE,
    parameter int CW     = 32
);
    logic [NSTAGE-1:0] stall_req;
    logic              flush_req;
    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] bubble;
    logic [NSTAGE-1:0] flush;
    logic              flush_pending;
    logic              hang;
    logic [CW-1:0]     stall_cycles;
    logic [CW-1:0]     flush_count;

    modport master (
        output stall_req, flush_req,
        input  stall, bubble, flush, flush_pending, hang,
               stall_cycles, flush_count
    );

    modport slave (
        input  stall_req, flush_req,
        output stall, bubble, flush, flush_pending, hang,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl_stall_watchdog.sv
// ---------------------------------------------------------------------------
// stall_watchdog
// Counts consecutive stalled cycles (saturating) and raises a sticky hang
// flag once TIMEOUT consecutive stalled cycles have been seen.
//   clk     in  rising-edge clock
//   rst     in  synchronous active-high reset
//   stalled in  any pipeline stage is held this cycle
//   hang    out sticky flag, cleared only by rst
// ---------------------------------------------------------------------------
module stall_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stalled,
    output logic hang
);
    localparam int              CNT_W   = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_hang;

    // NOTE: synchronous reset (sampled only on the clock edge), matching the
    // rest of the core; every state flop uses non-blocking assignment so all
    // registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_hang <= 1'b0;
        end else if (stalled) begin
            // Counter at TIMEOUT-1 on a stalled cycle means this is the
            // TIMEOUT-th consecutive one; hold the count there.
            if (r_cnt == CNT_MAX) r_hang <= 1'b1;
            else                  r_cnt  <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign hang = r_hang;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// N-stage stall/bubble generator with deferred branch-redirect flush and a
// stall watchdog. Drives the pipeline register hold/bubble/flush controls.
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset
//   bus  slave modport of pipe_hazard_ctrl_if:
//        stall_req/flush_req in; stall/bubble/flush/flush_pending/hang and
//        the stall_cycles/flush_count performance counters out.
// Build option: define PIPE_HAZARD_PERF_EN to implement the performance
// counters; otherwise they read as zero and no counter flops exist.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE      = DEF_NSTAGE,
    parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH,
    parameter int TIMEOUT     = 1024,
    parameter int CW          = 32
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [NSTAGE-1:0] FLUSH_MASK =
        {{(NSTAGE - FLUSH_DEPTH){1'b0}}, {FLUSH_DEPTH{1'b1}}};
    localparam logic [NSTAGE-1:0] PC_ONLY = {{(NSTAGE - 1){1'b0}}, 1'b1};

    hz_state_e         r_state, w_state_nxt;
    logic [NSTAGE-1:0] w_stall_raw;
    logic [NSTAGE-1:0] w_bubble_raw;
    logic [NSTAGE-1:0] w_stall, w_bubble, w_flush;
    logic              w_blocked;
    logic              w_fire;
    logic              w_hang;

    // A stage holds when it or any older stage requests a stall; the first
    // stage past the oldest requester gets the bubble.
    for (genvar i = 0; i < NSTAGE; i++) begin : g_prio
        assign w_stall_raw[i] = |bus.stall_req[NSTAGE-1:i];
        if (i == 0) begin : g_first
            assign w_bubble_raw[i] = 1'b0;
        end else begin : g_rest
            assign w_bubble_raw[i] = w_stall_raw[i-1] & ~w_stall_raw[i];
        end
    end

    // Redirect source is frozen whenever any stage at or past FLUSH_DEPTH stalls.
    assign w_blocked = w_stall_raw[FLUSH_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (bus.flush_req) begin
                    if (w_blocked) w_state_nxt = ST_PEND;
                    else           w_fire      = 1'b1;
                end
            end
            ST_PEND: begin
                // A new flush_req while pending merges: it changes nothing.
                if (!w_blocked) begin
                    w_fire      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        w_flush  = '0;
        w_stall  = PC_ONLY;
        w_bubble = '0;
        if (!rst) begin
            w_flush  = w_fire ? FLUSH_MASK : '0;
            w_stall  = w_stall_raw  & ~w_flush;
            w_bubble = w_bubble_raw & ~w_flush;
        end
    end

    stall_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .stalled (|w_stall),
        .hang    (w_hang)
    );

`ifdef PIPE_HAZARD_PERF_EN
    logic [CW-1:0] r_stall_cycles;
    logic [CW-1:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (|w_stall) r_stall_cycles <= r_stall_cycles + CW'(1);
            if (|w_flush) r_flush_count  <= r_flush_count  + CW'(1);
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_count  = r_flush_count;
`else
    assign bus.stall_cycles = '0;
    assign bus.flush_count  = '0;
`endif

    assign bus.stall         = w_stall;
    assign bus.bubble        = w_bubble;
    assign bus.flush         = w_flush;
    assign bus.flush_pending = (r_state == ST_PEND);
    assign bus.hang          = w_hang;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed scenarios followed by randomized traffic, every cycle compared
// against a behavioural model of the hazard rules.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
    localparam int NS = 5;
    localparam int FD = 2;
    localparam int TO = 8;
    localparam int CW = 32;
    localparam logic [NS-1:0] FMASK = 5'b00011;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_hazard_ctrl_if #(.NSTAGE(NS), .CW(CW)) bus ();

    pipe_hazard_ctrl #(
        .NSTAGE      (NS),
        .FLUSH_DEPTH (FD),
        .TIMEOUT     (TO),
        .CW          (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    bit          m_pend = 1'b0;
    int          m_run  = 0;
    bit          m_hang = 1'b0;
    logic [CW-1:0] m_scyc = '0;
    logic [CW-1:0] m_fcnt = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare all outputs with the model,
    // then advance the model to the state after the coming rising edge.
    task automatic step(input logic r, input logic [NS-1:0] sr, input logic fr);
        int            k;
        logic [NS-1:0] e_stall, e_bub, e_fl;
        bit            blocked, fire;
        logic [CW-1:0] e_sc, e_fc;
        @(negedge clk);
        rst           = r;
        bus.stall_req = sr;
        bus.flush_req = fr;
        #1;
        k = -1;
        for (int i = 0; i < NS; i++) if (sr[i]) k = i;
        blocked = (k >= FD);
        fire    = 1'b0;
        if (r) begin
            e_stall = 5'b00001;
            e_bub   = '0;
            e_fl    = '0;
        end else begin
            e_stall = '0;
            for (int i = 0; i <= k; i++) e_stall[i] = 1'b1;
            e_bub = '0;
            if (k >= 0 && k < NS - 1) e_bub[k+1] = 1'b1;
            fire  = !blocked && (m_pend || fr);
            e_fl  = fire ? FMASK : '0;
            e_stall = e_stall & ~e_fl;
            e_bub   = e_bub & ~e_fl;
        end
`ifdef PIPE_HAZARD_PERF_EN
        e_sc = m_scyc;
        e_fc = m_fcnt;
`else
        e_sc = '0;
        e_fc = '0;
`endif
        check("stall",         64'(bus.stall),         64'(e_stall));
        check("bubble",        64'(bus.bubble),        64'(e_bub));
        check("flush",         64'(bus.flush),         64'(e_fl));
        check("flush_pending", 64'(bus.flush_pending), 64'(m_pend));
        check("hang",          64'(bus.hang),          64'(m_hang));
        check("stall_cycles",  64'(bus.stall_cycles),  64'(e_sc));
        check("flush_count",   64'(bus.flush_count),   64'(e_fc));
        if (r) begin
            m_pend = 1'b0;
            m_run  = 0;
            m_hang = 1'b0;
            m_scyc = '0;
            m_fcnt = '0;
        end else begin
            m_pend = blocked && (m_pend || fr);
            if (e_stall != '0) begin
                if (m_run < TO) m_run++;
                m_scyc = m_scyc + 1'b1;
            end else begin
                m_run = 0;
            end
            if (m_run >= TO) m_hang = 1'b1;
            if (fire) m_fcnt = m_fcnt + 1'b1;
        end
    endtask

    initial begin
        logic [NS-1:0] sr;
        bus.stall_req = '0;
        bus.flush_req = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        step(1'b1, 5'b00000, 1'b0);
        check("rst_stall", 64'(bus.stall), 64'(5'b00001));
        step(1'b0, 5'b00000, 1'b0);
        check("post_rst_stall", 64'(bus.stall), 64'(0));

        // Priority encoding
        step(1'b0, 5'b01010, 1'b0);
        check("prio_stall",  64'(bus.stall),  64'(5'b01111));
        check("prio_bubble", 64'(bus.bubble), 64'(5'b10000));
        step(1'b0, 5'b00000, 1'b0);
        check("idle_stall", 64'(bus.stall), 64'(0));
        step(1'b0, 5'b10000, 1'b0);
        check("wb_bubble", 64'(bus.bubble), 64'(0));

        // Applicable redirect
        step(1'b0, 5'b00001, 1'b1);
        check("app_flush", 64'(bus.flush), 64'(5'b00011));
        check("app_stall", 64'(bus.stall), 64'(0));
        step(1'b0, 5'b00000, 1'b0);

        // Deferred redirect, with a merged second request in PEND
        step(1'b0, 5'b01000, 1'b1);
        step(1'b0, 5'b01000, 1'b1);
        check("def_pend1", 64'(bus.flush_pending), 64'(1));
        step(1'b0, 5'b01000, 1'b0);
        check("def_pend2", 64'(bus.flush_pending), 64'(1));
        step(1'b0, 5'b00000, 1'b1);
        check("def_flush", 64'(bus.flush), 64'(5'b00011));
        step(1'b0, 5'b00000, 1'b0);
        check("def_run", 64'(bus.flush_pending), 64'(0));

        // Reset while pending
        step(1'b0, 5'b01000, 1'b1);
        step(1'b1, 5'b01000, 1'b0);
        step(1'b1, 5'b01000, 1'b0);
        check("rstp_pend",  64'(bus.flush_pending), 64'(0));
        check("rstp_stall", 64'(bus.stall), 64'(5'b00001));
        step(1'b0, 5'b00000, 1'b0);
        check("rstp_noflush", 64'(bus.flush), 64'(0));

        // Watchdog: 7 stalled cycles do not hang, 8 do
        repeat (7) step(1'b0, 5'b00100, 1'b0);
        step(1'b0, 5'b00000, 1'b0);
        check("wd_7", 64'(bus.hang), 64'(0));
        repeat (8) step(1'b0, 5'b00100, 1'b0);
        step(1'b0, 5'b00000, 1'b0);
        check("wd_8", 64'(bus.hang), 64'(1));
        repeat (3) step(1'b0, 5'b00000, 1'b0);
        check("wd_sticky", 64'(bus.hang), 64'(1));
        step(1'b1, 5'b00000, 1'b0);
        step(1'b0, 5'b00000, 1'b0);
        check("wd_clear", 64'(bus.hang), 64'(0));

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       sr = '0;
                1:       sr = NS'(1) << $urandom_range(0, NS - 1);
                default: sr = NS'($urandom);
            endcase
            step(($urandom_range(0, 49) == 0), sr, ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard controller for the in-order RISC-V core. It replaces the fixed 5-stage stall priority encoder with an N-stage stall/bubble generator. It adds a deferred-flush mechanism for branch redirects that arrive while older stages are frozen, and a stall watchdog. It sits beside the pipeline registers and drives their hold, bubble and flush controls every cycle.

## Interface
- NSTAGE, 5, number of pipeline stages; stage 0 = PC register, stage NSTAGE-1 = writeback.
- FLUSH_DEPTH, 2, number of youngest stages (0..FLUSH_DEPTH-1) squashed by a redirect; range 1..NSTAGE-1.
- TIMEOUT, 1024, consecutive stalled cycles before `hang` asserts; must be ≥2.
- CW, 32, performance counter width.

- clk  in  1  rising-edge clock.
- rst  in  1  reset rst, synchronous, active-high.
- stall_req  in  NSTAGE  bit i = stage i cannot complete this cycle.
- flush_req  in  1  redirect (branch/jump mispredict) request, single-cycle pulse.
- stall  out  NSTAGE  bit i = stage i register holds its value.
- bubble  out  NSTAGE  bit i = stage i register loads a NOP.
- flush  out  NSTAGE  bit i = stage i register is cleared to NOP.
- flush_pending  out  1  a redirect is latched and not yet applied.
- hang  out  1  sticky watchdog flag.
- stall_cycles  out  CW  cycles with any stall bit set (PERF_EN only).
- flush_count  out  CW  flushes applied (PERF_EN only).

## Operation
- Let k = highest index with stall_req[k]=1. Then stall[i]=1 for all i≤k. If k<NSTAGE-1, bubble[k+1]=1. With no requester: stall=0, bubble=0.
- A redirect is *blocked* when k ≥ FLUSH_DEPTH, because the source stage is frozen. Otherwise it is *applicable*.
- States: RUN, PEND.
  - RUN, flush_req applicable: flush[FLUSH_DEPTH-1:0]=1 this cycle. Flush overrides stall and bubble on those bits. Stay in RUN.
  - RUN, flush_req blocked: go to PEND.
  - PEND, still blocked: hold. A new flush_req merges into the pending one (no double count).
  - PEND, not blocked: drive flush[FLUSH_DEPTH-1:0]=1 and return to RUN.
- flush_pending = (state==PEND).
- Watchdog:
  - A saturating counter increments on every cycle with stall≠0 and clears on any cycle with stall=0.
  - `hang` sets when the counter reaches TIMEOUT-1 while still stalled. It stays set until rst.
- Counters wrap modulo 2^CW.

## Timing
- stall, bubble and same-cycle flush are combinational from stall_req/flush_req, with zero latency.
- A pending flush is issued from the state register in the first cycle k < FLUSH_DEPTH. That is the cycle the blocking request drops, not one cycle later.
- While rst=1: stall=1 on bit 0 only (PC held), bubble=0, flush=0. The state goes to RUN, and the watchdog counter, hang and the perf counters clear.
- rst overrides all inputs. A pending flush at reset is discarded.
- rst deasserts with no requests: stall=0 in the next cycle.
- A flush_req in the same cycle PEND resolves produces one flush pulse and one flush_count increment.
- The hang flag is registered: it is visible the cycle after the TIMEOUT-th consecutive stalled cycle.

## Configuration
- PIPE_HAZARD_PERF_EN defined: stall_cycles and flush_count exist and count as specified.
- PIPE_HAZARD_PERF_EN undefined: both ports are tied to 0 and no counter flops are synthesised. All other behaviour is identical.

## Structure
- Package pipe_ctrl_pkg holds:
  - the stage index constants (PC, IF, ID, EX, MEM, WB);
  - the RUN/PEND state enum;
  - the default NSTAGE and FLUSH_DEPTH values, shared with the pipeline top.
- Sub-module stall_watchdog (parameters TIMEOUT; ports clk, rst, stalled, hang) contains the saturating counter and the sticky flag.
- The priority encoder and flush FSM stay in pipe_hazard_ctrl.

## Test plan
- Priority: stall_req=5'b01010 → stall=5'b01111, bubble=5'b10000, flush=0. stall_req=0 → all zero.
- Applicable redirect: stall_req=5'b00001 with flush_req=1 → flush=5'b00011, stall=0, flush_count +1, flush_pending=0.
- Deferred redirect: stall_req=5'b01000 held 3 cycles with flush_req pulsed in cycle 0 → flush_pending=1 for cycles 1–2. Cycle 3 drops the request → flush=5'b00011 in cycle 3, state back to RUN.
- Reset mid-PEND: rst in PEND → flush_pending=0, stall=5'b00001. No flush pulse after rst deasserts.
- Watchdog (TIMEOUT=8): stall_req=5'b00100 held 7 cycles → hang=0. 8 cycles → hang=1 on the 9th and still 1 after stalls end, until rst.
- Macro off: stall_cycles and flush_count read 0 across the deferred-redirect scenario. All other outputs are bit-identical to the PERF_EN build.
